sys_ctrl_gen: RTL and testbench

Parametrised host-side boot/debug controller between a byte-stream UART pair and a word-wide memory request port. It executes a small UART command set: set address and length, load bytes into memory, dump bytes from memory, run the core and halt the core. It owns the memory bus until RUN, then hands the bus to the core. It generalises the first-generation controller in four ways: configurable memory and address width, full request/grant handshaking, explicit core run/halt, and a sticky overrun flag.

---
 rtl/sys_ctrl_gen.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sys_ctrl_gen.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_gen.sv
// -----------------------------------------------------------------------------
// sys_ctrl_gen
//   Host-side boot/debug controller. Executes a small UART command set that
//   loads bytes into, or dumps bytes out of, a word-wide memory port, and
//   starts/stops the core. The block owns the memory bus until RUN, then hands
//   it to the core until HALT.
//
//   Commands (accepted in IDLE only):
//     0x30 SETUP  4 address bytes then 4 length bytes, MSB first, then ACK
//     0x31 LOAD   len_cnt data bytes, each written to addr_cnt, then ACK
//     0x32 DUMP   len_cnt bytes read from addr_cnt and transmitted, then ACK
//     0x33 RUN    ACK, then release the core and the memory bus
//     0x34 HALT   (in RUN only) reclaim the bus, hold the core, ACK
//
//   Optional feature: define SYS_CTRL_CHECKSUM_EN to send an 8-bit running
//   sum of the LOAD/DUMP payload just before the ACK.
//
// Parameters
//   ADDR_W   byte-address width (16..32)
//   DATA_W   memory word width, power of two 8..512; NB = DATA_W/8 lanes
//
// Ports
//   clk, resetn                  clock, asynchronous active-low reset
//   rx_valid, rx_data            received UART byte (one-cycle pulse)
//   tx_en, tx_data, tx_busy      UART transmit handshake
//   mem_req/we/addr/wdata/strb   memory request, held until mem_gnt
//   mem_gnt                      request accepted this cycle
//   mem_rvalid, mem_rdata        read return (unbounded latency)
//   core_en, core_reset          core clock enable / active-high reset
//   mem_bus_ctrl                 0 = this block owns memory, 1 = core
//   rx_overrun                   sticky: byte arrived while a write was pending
// -----------------------------------------------------------------------------
module sys_ctrl_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 rx_valid,
    input  logic [7:0]                           rx_data,
    output logic                                 tx_en,
    output logic [7:0]                           tx_data,
    input  logic                                 tx_busy,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_W-$clog2(DATA_W/8)-1:0]   mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    output logic [DATA_W/8-1:0]                  mem_strb,
    input  logic                                 mem_gnt,
    input  logic                                 mem_rvalid,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic                                 core_en,
    output logic                                 core_reset,
    output logic                                 mem_bus_ctrl,
    output logic                                 rx_overrun
);

    localparam int NB  = DATA_W / 8;
    localparam int LB  = $clog2(NB);
    localparam int LBX = (LB > 0) ? LB : 1;

    localparam logic [7:0] CMD_SETUP = 8'h30;
    localparam logic [7:0] CMD_LOAD  = 8'h31;
    localparam logic [7:0] CMD_DUMP  = 8'h32;
    localparam logic [7:0] CMD_RUN   = 8'h33;
    localparam logic [7:0] CMD_HALT  = 8'h34;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SET_A  = 4'd1;
    localparam logic [3:0] S_SET_L  = 4'd2;
    localparam logic [3:0] S_L_WAIT = 4'd3;
    localparam logic [3:0] S_L_REQ  = 4'd4;
    localparam logic [3:0] S_D_REQ  = 4'd5;
    localparam logic [3:0] S_D_WAIT = 4'd6;
    localparam logic [3:0] S_D_TX   = 4'd7;
    localparam logic [3:0] S_CSUM   = 4'd8;
    localparam logic [3:0] S_ACK    = 4'd9;   // ACK then IDLE
    localparam logic [3:0] S_RACK   = 4'd10;  // ACK then RUN
    localparam logic [3:0] S_RUN    = 4'd11;

`ifdef SYS_CTRL_CHECKSUM_EN
    localparam logic [3:0] S_XFER_END = S_CSUM;
`else
    localparam logic [3:0] S_XFER_END = S_ACK;
`endif

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    logic [3:0]        state;
    logic [1:0]        bcnt;      // byte index within a 4-byte SETUP field
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       len_cnt;
    logic [7:0]        wbyte;     // byte being written (LOAD)
    logic [7:0]        dbyte;     // byte read back (DUMP)
    logic [LBX-1:0]    lane;
    logic [7:0]        rd_lane;
    logic              last_byte;
    logic              tx_fire;

    generate
        if (LB > 0) begin : g_lane
            assign lane = addr_cnt[LBX-1:0];
        end else begin : g_nolane
            assign lane = '0;
        end
    endgenerate

    assign rd_lane   = mem_rdata[{lane, 3'b000} +: 8];
    assign last_byte = (len_cnt == 32'd1);

    // Request fields derive only from registered state, so they cannot move
    // while a request waits for its grant.
    assign mem_req   = (state == S_L_REQ) || (state == S_D_REQ);
    assign mem_we    = (state == S_L_REQ);
    assign mem_addr  = addr_cnt[ADDR_W-1:LB];
    assign mem_wdata = {NB{wbyte}};
    assign mem_strb  = mem_req ? (NB'(1) << lane) : '0;

    assign tx_fire = !tx_busy && ((state == S_D_TX) || (state == S_CSUM) ||
                                  (state == S_ACK)  || (state == S_RACK));
    assign tx_en   = tx_fire;

`ifdef SYS_CTRL_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        tx_data = 8'h00;
        if (tx_fire) begin
            if (state == S_D_TX)      tx_data = dbyte;
            else if (state == S_CSUM) tx_data = csum;
            else                      tx_data = ACK_BYTE;
        end
    end
`else
    always_comb begin
        tx_data = 8'h00;
        if (tx_fire) tx_data = (state == S_D_TX) ? dbyte : ACK_BYTE;
    end
`endif

    // Core controls follow the RUN state one cycle late.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_en      <= 1'b0;
            core_reset   <= 1'b1;
            mem_bus_ctrl <= 1'b0;
        end else begin
            core_en      <= (state == S_RUN);
            core_reset   <= (state != S_RUN);
            mem_bus_ctrl <= (state == S_RUN);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            bcnt       <= 2'd0;
            addr_cnt   <= '0;
            len_cnt    <= 32'd0;
            wbyte      <= 8'h00;
            dbyte      <= 8'h00;
            rx_overrun <= 1'b0;
`ifdef SYS_CTRL_CHECKSUM_EN
            csum       <= 8'h00;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        bcnt <= 2'd0;
                        case (rx_data)
                            CMD_SETUP: begin
                                state      <= S_SET_A;
                                rx_overrun <= 1'b0;
                            end
                            CMD_LOAD: begin
                                state <= (len_cnt == 32'd0) ? S_XFER_END : S_L_WAIT;
`ifdef SYS_CTRL_CHECKSUM_EN
                                csum  <= 8'h00;
`endif
                            end
                            CMD_DUMP: begin
                                state <= (len_cnt == 32'd0) ? S_XFER_END : S_D_REQ;
`ifdef SYS_CTRL_CHECKSUM_EN
                                csum  <= 8'h00;
`endif
                            end
                            CMD_RUN: state <= S_RACK;
                            default: ;
                        endcase
                    end
                end
                S_SET_A: begin
                    if (rx_valid) begin
                        // Keeps the low ADDR_W bits of the 32-bit field.
                        addr_cnt <= {addr_cnt[ADDR_W-9:0], rx_data};
                        bcnt     <= bcnt + 2'd1;
                        if (bcnt == 2'd3) state <= S_SET_L;
                    end
                end
                S_SET_L: begin
                    if (rx_valid) begin
                        len_cnt <= {len_cnt[23:0], rx_data};
                        bcnt    <= bcnt + 2'd1;
                        if (bcnt == 2'd3) state <= S_ACK;
                    end
                end
                S_L_WAIT: begin
                    if (rx_valid) begin
                        wbyte <= rx_data;
                        state <= S_L_REQ;
`ifdef SYS_CTRL_CHECKSUM_EN
                        csum  <= csum + rx_data;
`endif
                    end
                end
                S_L_REQ: begin
                    // No buffer for a second byte: flag it and drop it.
                    if (rx_valid) rx_overrun <= 1'b1;
                    if (mem_gnt) begin
                        addr_cnt <= addr_cnt + ADDR_ONE;
                        len_cnt  <= len_cnt - 32'd1;
                        state    <= last_byte ? S_XFER_END : S_L_WAIT;
                    end
                end
                S_D_REQ: begin
                    if (mem_gnt) begin
                        // Zero-latency memories return data with the grant.
                        if (mem_rvalid) begin
                            dbyte <= rd_lane;
                            state <= S_D_TX;
                        end else begin
                            state <= S_D_WAIT;
                        end
                    end
                end
                S_D_WAIT: begin
                    if (mem_rvalid) begin
                        dbyte <= rd_lane;
                        state <= S_D_TX;
                    end
                end
                S_D_TX: begin
                    if (!tx_busy) begin
                        addr_cnt <= addr_cnt + ADDR_ONE;
                        len_cnt  <= len_cnt - 32'd1;
                        state    <= last_byte ? S_XFER_END : S_D_REQ;
`ifdef SYS_CTRL_CHECKSUM_EN
                        csum     <= csum + dbyte;
`endif
                    end
                end
`ifdef SYS_CTRL_CHECKSUM_EN
                S_CSUM: if (!tx_busy) state <= S_ACK;
`endif
                S_ACK:  if (!tx_busy) state <= S_IDLE;
                S_RACK: if (!tx_busy) state <= S_RUN;
                S_RUN:  if (rx_valid && (rx_data == CMD_HALT)) state <= S_ACK;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_gen.sv
module tb_sys_ctrl_gen;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int AW     = 28;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_busy = 1'b0;
    logic              mem_req, mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0]       mem_strb;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              core_en, core_reset, mem_bus_ctrl, rx_overrun;

    sys_ctrl_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .core_en(core_en),
        .core_reset(core_reset), .mem_bus_ctrl(mem_bus_ctrl), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: timed out", nm);
    endtask

    // ---------------- environment: tx sink, busy generator, memory ----------
    logic [7:0] txq[$];
    int busy_viol = 0;
    bit busy_mode = 0;

    always @(negedge clk) begin
        if (resetn && tx_en) begin
            txq.push_back(tx_data);
            if (tx_busy) busy_viol++;
        end
    end

    always @(posedge clk) begin
        #1 tx_busy = busy_mode ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    typedef struct { logic [AW-1:0] addr; logic [15:0] strb; logic [DATA_W-1:0] data; } wr_t;
    wr_t wrq[$];
    int wr_total = 0;
    int req_cnt  = 0;
    int gmode    = 0;   // 0: grant at once, 1: random 0..10, 2: fixed 8
    int rlat     = 3;
    logic [DATA_W-1:0] mem [logic [AW-1:0]];

    bit in_req = 0, rpend = 0;
    int gdly = 0, rcnt = 0;
    logic [DATA_W-1:0] rword;
    logic [172:0] snap;
    bit s_bad = 0;

    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (!resetn) begin
            in_req = 0;
            rpend  = 0;
        end else begin
            if (rpend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rword;
                    rpend      = 0;
                end else rcnt--;
            end
            if (mem_req) begin
                if (!in_req) begin
                    in_req = 1;
                    s_bad  = 0;
                    req_cnt++;
                    snap = {mem_we, mem_addr, mem_strb, mem_wdata};
                    gdly = (gmode == 1) ? int'($urandom_range(0, 10)) : (gmode == 2) ? 8 : 0;
                end else if ({mem_we, mem_addr, mem_strb, mem_wdata} !== snap) begin
                    s_bad = 1;
                end
                if (gdly == 0) begin
                    mem_gnt = 1'b1;
                    in_req  = 0;
                    check("req_stable", DATA_W'(s_bad), '0);
                    if (mem_we) begin
                        wr_t w;
                        logic [DATA_W-1:0] cur;
                        w.addr = mem_addr; w.strb = mem_strb; w.data = mem_wdata;
                        wrq.push_back(w);
                        wr_total++;
                        cur = mem.exists(mem_addr) ? mem[mem_addr] : '0;
                        for (int i = 0; i < 16; i++)
                            if (mem_strb[i]) cur[i*8 +: 8] = mem_wdata[i*8 +: 8];
                        mem[mem_addr] = cur;
                    end else begin
                        rword = mem.exists(mem_addr) ? mem[mem_addr] : '0;
                        if (rlat == 0) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = rword;
                        end else begin
                            rpend = 1;
                            rcnt  = rlat - 1;
                        end
                    end
                end else gdly--;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic chk_tx(input string nm, input logic [7:0] exp);
        int n = 0;
        while (txq.size() == 0 && n < 400) begin @(negedge clk); n++; end
        if (txq.size() == 0) timeout(nm);
        else check(nm, DATA_W'(txq.pop_front()), DATA_W'(exp));
    endtask

    task automatic end_xfer(input logic [7:0] cs);
`ifdef SYS_CTRL_CHECKSUM_EN
        chk_tx("csum", cs);
`endif
        chk_tx("ack", 8'h06);
    endtask

    task automatic setup(input logic [31:0] a, input logic [31:0] l);
        send_byte(8'h30);
        for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) send_byte(l[i*8 +: 8]);
        chk_tx("setup_ack", 8'h06);
    endtask

    task automatic wait_wr(input int tgt);
        int n = 0;
        while (wr_total < tgt && n < 200) begin @(negedge clk); n++; end
        if (wr_total < tgt) timeout("write");
    endtask

    task automatic load_byte(input logic [7:0] b);
        int tgt = wr_total + 1;
        send_byte(b);
        wait_wr(tgt);
    endtask

    task automatic chk_wr(input string nm, input logic [AW-1:0] a, input logic [15:0] s, input logic [7:0] d);
        if (wrq.size() == 0) timeout(nm);
        else begin
            wr_t w = wrq.pop_front();
            check({nm, "_addr"}, DATA_W'(w.addr), DATA_W'(a));
            check({nm, "_strb"}, DATA_W'(w.strb), DATA_W'(s));
            check({nm, "_wdata"}, w.data, {16{d}});
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        check(nm, DATA_W'({tx_en, tx_data, mem_req, mem_we, mem_addr, mem_strb,
                           core_en, core_reset, mem_bus_ctrl, rx_overrun}),
              DATA_W'({1'b0, 8'h00, 1'b0, 1'b0, 28'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0}));
        check({nm, "_wdata"}, mem_wdata, '0);
    endtask

    // ---------------- vector table -------------------------------------------
    typedef struct {
        logic [31:0]   addr;
        logic [7:0]    data;
        logic [AW-1:0] exp_waddr;
        logic [15:0]   exp_strb;
    } vec_t;
    vec_t vt[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, w0;
        vt[0] = '{32'h0100_0103, 8'hAA, 28'h010_0010, 16'h0008};
        vt[1] = '{32'h0000_0000, 8'h5A, 28'h000_0000, 16'h0001};
        vt[2] = '{32'h0000_000F, 8'hC3, 28'h000_0000, 16'h8000};
        vt[3] = '{32'hFFFF_FFF7, 8'h11, 28'hFFF_FFFF, 16'h0080};
        vt[4] = '{32'h1234_5678, 8'h7E, 28'h123_4567, 16'h0100};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("reset");
        resetn = 1'b1;

        // Single-byte loads across lanes and address extremes
        gmode = 1;
        for (int i = 0; i < 5; i++) begin
            setup(vt[i].addr, 32'd1);
            send_byte(8'h31);
            load_byte(vt[i].data);
            chk_wr($sformatf("vec%0d", i), vt[i].exp_waddr, vt[i].exp_strb, vt[i].data);
            end_xfer(vt[i].data);
        end

        // Two-byte LOAD crossing lane 3 -> 4, random grant delays
        setup(32'h0100_0103, 32'd2);
        send_byte(8'h31);
        load_byte(8'hAA);
        load_byte(8'hBB);
        chk_wr("load0", 28'h010_0010, 16'h0008, 8'hAA);
        chk_wr("load1", 28'h010_0010, 16'h0010, 8'hBB);
        end_xfer(8'h65);

        // DUMP back with 3-cycle read latency and transmitter stalls
        setup(32'h0100_0103, 32'd2);
        busy_mode = 1;
        rlat = 3;
        r0 = req_cnt;
        send_byte(8'h32);
        chk_tx("dump0", 8'hAA);
        chk_tx("dump1", 8'hBB);
        end_xfer(8'h65);
        check("dump_req_count", DATA_W'(req_cnt - r0), DATA_W'(2));
        busy_mode = 0;

        // Address wrap on LOAD, then DUMP with grant and rvalid together
        setup(32'hFFFF_FFFF, 32'd2);
        send_byte(8'h31);
        load_byte(8'h01);
        load_byte(8'h02);
        chk_wr("wrap0", 28'hFFF_FFFF, 16'h8000, 8'h01);
        chk_wr("wrap1", 28'h000_0000, 16'h0001, 8'h02);
        end_xfer(8'h03);
        setup(32'hFFFF_FFFF, 32'd2);
        gmode = 0;
        rlat  = 0;
        send_byte(8'h32);
        chk_tx("wdump0", 8'h01);
        chk_tx("wdump1", 8'h02);
        end_xfer(8'h03);

        // Zero length: no memory traffic, straight to the end sequence
        setup(32'h0000_0040, 32'd0);
        r0 = req_cnt;
        send_byte(8'h31);
        end_xfer(8'h00);
        send_byte(8'h32);
        end_xfer(8'h00);
        check("len0_no_req", DATA_W'(req_cnt - r0), '0);

        // Byte arriving during a stalled write
        gmode = 2;
        rlat  = 3;
        setup(32'h0000_0020, 32'd1);
        w0 = wr_total;
        send_byte(8'h31);
        send_byte(8'h44);
        send_byte(8'h99);
        wait_wr(w0 + 1);
        chk_wr("ovr", 28'h000_0002, 16'h0001, 8'h44);
        end_xfer(8'h44);
        repeat (10) @(negedge clk);
        check("ovr_single_write", DATA_W'(wr_total - w0), DATA_W'(1));
        check("ovr_flag", DATA_W'(rx_overrun), DATA_W'(1));

        // RUN / HALT
        gmode = 1;
        send_byte(8'h33);
        chk_tx("run_ack", 8'h06);
        repeat (2) @(negedge clk);
        check("run_core", DATA_W'({core_en, core_reset, mem_bus_ctrl}), DATA_W'(3'b101));
        r0 = req_cnt;
        send_byte(8'h31);
        repeat (15) @(negedge clk);
        check("run_ignore_tx", DATA_W'(txq.size()), '0);
        check("run_ignore_req", DATA_W'(req_cnt - r0), '0);
        check("run_ovr_sticky", DATA_W'(rx_overrun), DATA_W'(1));
        send_byte(8'h34);
        chk_tx("halt_ack", 8'h06);
        repeat (2) @(negedge clk);
        check("halt_core", DATA_W'({core_en, core_reset, mem_bus_ctrl}), DATA_W'(3'b010));

        // SETUP clears the overrun flag
        setup(32'h0000_0000, 32'd4);
        check("ovr_cleared", DATA_W'(rx_overrun), '0);

        // Reset in the middle of a DUMP
        gmode = 0;
        rlat  = 6;
        send_byte(8'h32);
        repeat (2) @(posedge clk);
        #2 resetn = 1'b0;
        #1 chk_reset_outs("mid_reset");
        txq.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        r0 = req_cnt;
        repeat (20) @(negedge clk);
        check("mid_reset_no_tx", DATA_W'(txq.size()), '0);
        check("mid_reset_no_req", DATA_W'(req_cnt - r0), '0);
        // len_cnt returned to 0: a DUMP now only closes out
        send_byte(8'h32);
        end_xfer(8'h00);
        check("post_reset_no_req", DATA_W'(req_cnt - r0), '0);

        check("tx_busy_respected", DATA_W'(busy_viol), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
